// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared types and constants for the CPU/DMA bus arbiter.
//   arb_state_t   : arbiter FSM states (IDLE, ACCESS, DONE)
//   arb_id_t      : requester identity (ARB_CPU, ARB_DMA)
//   arb_req_t     : one latched bus request (address, data, write, space)
//   ARB_CNT_W     : width of the wait-cycle counter; wait counts must fit in it
//   arb_wait_load : picks the wait count for an access from its space select
package mycpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  typedef enum logic {
    ARB_CPU,
    ARB_DMA
  } arb_id_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
    logic        wen;
    logic        iom;
  } arb_req_t;

  localparam int unsigned ARB_CNT_W   = 4;
  localparam int unsigned ARB_CNT_MAX = (1 << ARB_CNT_W) - 1;

  // Wait count for an access: IO space uses wait_io, memory uses wait_mem.
  // Values beyond the counter range are clamped so a bad parameter cannot
  // silently wrap to a short wait.
  function automatic logic [ARB_CNT_W-1:0] arb_wait_load(
    input logic        iom,
    input int unsigned wait_mem,
    input int unsigned wait_io
  );
    int unsigned w;
    w = iom ? wait_io : wait_mem;
    if (w > ARB_CNT_MAX) w = ARB_CNT_MAX;
    return w[ARB_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: all requester-side and pin-side signals of the bus arbiter.
//   cpu_* / dma_* : request inputs (req, a, d, wen, iom) and responses
//                   (rdy pulse, read data) for each requester
//   a_out, d_out, wen_out, iom_out : bus pins driven by the arbiter
//   d_in, io_in   : read data returned from memory and IO
//   cpu_grants_out, dma_grants_out : grant counters, only with BUS_ARB_PERF_EN
// Modports: slave = the arbiter itself, master = requesters and bus model.
interface bus_arbiter_if;

  logic        cpu_req_in;
  logic [15:0] cpu_a_in;
  logic [15:0] cpu_d_in;
  logic        cpu_wen_in;
  logic        cpu_iom_in;
  logic        cpu_rdy_out;
  logic [15:0] cpu_d_out;

  logic        dma_req_in;
  logic [15:0] dma_a_in;
  logic [15:0] dma_d_in;
  logic        dma_wen_in;
  logic        dma_iom_in;
  logic        dma_rdy_out;
  logic [15:0] dma_d_out;

  logic [15:0] a_out;
  logic [15:0] d_out;
  logic        wen_out;
  logic        iom_out;
  logic [15:0] d_in;
  logic [15:0] io_in;

`ifdef BUS_ARB_PERF_EN
  logic [15:0] cpu_grants_out;
  logic [15:0] dma_grants_out;
`endif

  modport slave (
    input  cpu_req_in, cpu_a_in, cpu_d_in, cpu_wen_in, cpu_iom_in,
    output cpu_rdy_out, cpu_d_out,
    input  dma_req_in, dma_a_in, dma_d_in, dma_wen_in, dma_iom_in,
    output dma_rdy_out, dma_d_out,
    output a_out, d_out, wen_out, iom_out,
    input  d_in, io_in
`ifdef BUS_ARB_PERF_EN
    , output cpu_grants_out, dma_grants_out
`endif
  );

  modport master (
    output cpu_req_in, cpu_a_in, cpu_d_in, cpu_wen_in, cpu_iom_in,
    input  cpu_rdy_out, cpu_d_out,
    output dma_req_in, dma_a_in, dma_d_in, dma_wen_in, dma_iom_in,
    input  dma_rdy_out, dma_d_out,
    input  a_out, d_out, wen_out, iom_out,
    output d_in, io_in
`ifdef BUS_ARB_PERF_EN
    , input cpu_grants_out, dma_grants_out
`endif
  );

endinterface

// File: rtl/arb_wait_cnt.sv
// arb_wait_cnt: loadable down-counter that times the wait cycles of one
// bus access.
//   clk, rst : clock, asynchronous active-high reset
//   load     : load load_val (takes priority over counting)
//   load_val : number of extra wait cycles for the access
//   en       : count down by one per cycle; holds at zero
//   zero     : counter is zero (last cycle of the access)
module arb_wait_cnt
  import mycpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ARB_CNT_W-1:0] load_val,
  input  logic                 en,
  output logic                 zero
);

  logic [ARB_CNT_W-1:0] count;

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the external memory/IO bus between the CPU and a DMA
// engine. One requester is granted at a time (round-robin on ties), the
// request is latched, the bus is held for 1+W cycles (W = WAIT_MEM or
// WAIT_IO), read data is captured in the last bus cycle and the grantee sees
// a one-cycle rdy pulse in the following DONE cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : bus_arbiter_if.slave carrying both requesters and the pins
// Parameters: WAIT_MEM (memory wait cycles), WAIT_IO (IO wait cycles), each
// at most 15.
// Optional feature, macro BUS_ARB_PERF_EN: saturating 16-bit grant counters
// per requester on bus.cpu_grants_out / bus.dma_grants_out.
module bus_arbiter
  import mycpu_pkg::*;
#(
  parameter int unsigned WAIT_MEM = 1,
  parameter int unsigned WAIT_IO  = 2
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  bus
);

  arb_state_t state, state_next;
  arb_id_t    grant;       // requester owning the current access
  arb_id_t    last_grant;  // loser of the next tie
  arb_req_t   req_q;       // request latched at grant time

  logic           grant_en;
  arb_id_t        grant_sel;
  arb_req_t       sel_req;
  logic           cnt_load;
  logic           cnt_en;
  logic           cnt_zero;
  logic           in_access;
  logic           last_cycle;
  logic [15:0]    rd_bus;
  logic [15:0]    cpu_rdata;
  logic [15:0]    dma_rdata;

  // Request fields of whichever requester the grant logic selects.
  assign sel_req = (grant_sel == ARB_CPU)
                 ? '{a: bus.cpu_a_in, d: bus.cpu_d_in, wen: bus.cpu_wen_in, iom: bus.cpu_iom_in}
                 : '{a: bus.dma_a_in, d: bus.dma_d_in, wen: bus.dma_wen_in, iom: bus.dma_iom_in};

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state, grant decision, counter control
  // ---------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    grant_en   = 1'b0;
    grant_sel  = ARB_CPU;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.cpu_req_in && bus.dma_req_in) begin
          // Tie: the requester that did not win last time goes now.
          grant_en  = 1'b1;
          grant_sel = (last_grant == ARB_CPU) ? ARB_DMA : ARB_CPU;
        end else if (bus.cpu_req_in) begin
          grant_en  = 1'b1;
          grant_sel = ARB_CPU;
        end else if (bus.dma_req_in) begin
          grant_en  = 1'b1;
          grant_sel = ARB_DMA;
        end
        if (grant_en) begin
          cnt_load   = 1'b1;
          state_next = ACCESS;
        end
      end

      ACCESS: begin
        cnt_en = 1'b1;
        if (cnt_zero) state_next = DONE;
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  arb_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (arb_wait_load(sel_req.iom, WAIT_MEM, WAIT_IO)),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  assign in_access  = (state == ACCESS);
  assign last_cycle = in_access && cnt_zero;
  assign rd_bus     = req_q.iom ? bus.io_in : bus.d_in;

  // ---------------------------------------------------------------------
  // Grant bookkeeping, request latch and read-data capture
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= ARB_CPU;
      last_grant <= ARB_DMA;  // CPU wins the first tie after reset
      req_q      <= '0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      if (grant_en) begin
        grant      <= grant_sel;
        last_grant <= grant_sel;
        req_q      <= sel_req;
      end
      // Loaded on writes too; the value is then simply whatever the bus held.
      if (last_cycle) begin
        if (grant == ARB_CPU) cpu_rdata <= rd_bus;
        else                  dma_rdata <= rd_bus;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: decoded from registers only, so no input reaches a pin
  // combinationally. Bus pins are forced to 0 outside ACCESS, and the write
  // strobe is confined to the last ACCESS cycle.
  // ---------------------------------------------------------------------
  assign bus.a_out       = in_access ? req_q.a   : '0;
  assign bus.d_out       = in_access ? req_q.d   : '0;
  assign bus.iom_out     = in_access & req_q.iom;
  assign bus.wen_out     = last_cycle & req_q.wen;

  assign bus.cpu_rdy_out = (state == DONE) && (grant == ARB_CPU);
  assign bus.dma_rdy_out = (state == DONE) && (grant == ARB_DMA);
  assign bus.cpu_d_out   = cpu_rdata;
  assign bus.dma_d_out   = dma_rdata;

`ifdef BUS_ARB_PERF_EN
  logic [15:0] cpu_grants_q;
  logic [15:0] dma_grants_q;

  // Saturating grant counters; cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_grants_q <= '0;
      dma_grants_q <= '0;
    end else if (grant_en) begin
      if (grant_sel == ARB_CPU) begin
        if (cpu_grants_q != 16'hFFFF) cpu_grants_q <= cpu_grants_q + 16'd1;
      end else begin
        if (dma_grants_q != 16'hFFFF) dma_grants_q <= dma_grants_q + 16'd1;
      end
    end
  end

  assign bus.cpu_grants_out = cpu_grants_q;
  assign bus.dma_grants_out = dma_grants_q;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter.
// A default-parameter instance covers reads, writes, IO waits, round-robin
// fairness, request latching and mid-access reset; a second instance with
// zero wait cycles covers the single-cycle ACCESS case. Grant counters are
// exercised when BUS_ARB_PERF_EN is defined.
module tb_bus_arbiter;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  bus_arbiter_if bus_if ();
  bus_arbiter_if bus0_if ();

  bus_arbiter #(.WAIT_MEM(1), .WAIT_IO(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  bus_arbiter #(.WAIT_MEM(0), .WAIT_IO(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.cpu_req_in = 0; bus_if.cpu_a_in = 0; bus_if.cpu_d_in = 0;
    bus_if.cpu_wen_in = 0; bus_if.cpu_iom_in = 0;
    bus_if.dma_req_in = 0; bus_if.dma_a_in = 0; bus_if.dma_d_in = 0;
    bus_if.dma_wen_in = 0; bus_if.dma_iom_in = 0;
    bus_if.d_in = 0; bus_if.io_in = 0;
    bus0_if.cpu_req_in = 0; bus0_if.cpu_a_in = 0; bus0_if.cpu_d_in = 0;
    bus0_if.cpu_wen_in = 0; bus0_if.cpu_iom_in = 0;
    bus0_if.dma_req_in = 0; bus0_if.dma_a_in = 0; bus0_if.dma_d_in = 0;
    bus0_if.dma_wen_in = 0; bus0_if.dma_iom_in = 0;
    bus0_if.d_in = 0; bus0_if.io_in = 0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();

    // ---- Reset state ----
    check("rst_a_out",   bus_if.a_out,            16'h0000);
    check("rst_d_out",   bus_if.d_out,            16'h0000);
    check("rst_wen_out", 16'(bus_if.wen_out),     16'h0000);
    check("rst_iom_out", 16'(bus_if.iom_out),     16'h0000);
    check("rst_cpu_rdy", 16'(bus_if.cpu_rdy_out), 16'h0000);
    check("rst_dma_rdy", 16'(bus_if.dma_rdy_out), 16'h0000);
    check("rst_cpu_d",   bus_if.cpu_d_out,        16'h0000);
    check("rst_dma_d",   bus_if.dma_d_out,        16'h0000);
    rst = 1'b0;

    // ---- CPU memory read, W=1: ACCESS cycles 1-2, rdy cycle 3 ----
    bus_if.cpu_req_in = 1; bus_if.cpu_a_in = 16'h0040;
    bus_if.d_in = 16'hBEEF; bus_if.io_in = 16'h1111;
    tick();  // cycle 1
    check("rd_c1_a_out",   bus_if.a_out,            16'h0040);
    check("rd_c1_iom",     16'(bus_if.iom_out),     16'h0000);
    check("rd_c1_cpu_rdy", 16'(bus_if.cpu_rdy_out), 16'h0000);
    tick();  // cycle 2
    check("rd_c2_a_out",   bus_if.a_out,            16'h0040);
    check("rd_c2_wen",     16'(bus_if.wen_out),     16'h0000);
    tick();  // cycle 3
    check("rd_c3_cpu_rdy", 16'(bus_if.cpu_rdy_out), 16'h0001);
    check("rd_c3_cpu_d",   bus_if.cpu_d_out,        16'hBEEF);
    check("rd_c3_dma_rdy", 16'(bus_if.dma_rdy_out), 16'h0000);
    check("rd_c3_a_out",   bus_if.a_out,            16'h0000);
    bus_if.cpu_req_in = 0;
    tick();  // IDLE
    check("rd_c4_cpu_rdy", 16'(bus_if.cpu_rdy_out), 16'h0000);

    // ---- DMA IO write, W=2: ACCESS cycles 1-3, wen only in 3, rdy at 4 ----
    bus_if.dma_req_in = 1; bus_if.dma_a_in = 16'h0003; bus_if.dma_d_in = 16'h1234;
    bus_if.dma_wen_in = 1; bus_if.dma_iom_in = 1;
    tick();  // cycle 1
    check("wr_c1_a_out", bus_if.a_out,        16'h0003);
    check("wr_c1_d_out", bus_if.d_out,        16'h1234);
    check("wr_c1_iom",   16'(bus_if.iom_out), 16'h0001);
    check("wr_c1_wen",   16'(bus_if.wen_out), 16'h0000);
    tick();  // cycle 2
    check("wr_c2_wen",   16'(bus_if.wen_out), 16'h0000);
    tick();  // cycle 3
    check("wr_c3_wen",   16'(bus_if.wen_out), 16'h0001);
    check("wr_c3_d_out", bus_if.d_out,        16'h1234);
    tick();  // cycle 4
    check("wr_c4_dma_rdy", 16'(bus_if.dma_rdy_out), 16'h0001);
    check("wr_c4_cpu_rdy", 16'(bus_if.cpu_rdy_out), 16'h0000);
    check("wr_c4_wen",     16'(bus_if.wen_out),     16'h0000);
    check("wr_c4_iom",     16'(bus_if.iom_out),     16'h0000);
    bus_if.dma_req_in = 0; bus_if.dma_wen_in = 0; bus_if.dma_iom_in = 0;
    tick();

    // ---- Fairness: both requesting continuously after reset ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.cpu_req_in = 1; bus_if.cpu_a_in = 16'h0100;
    bus_if.dma_req_in = 1; bus_if.dma_a_in = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      bus_if.d_in = 16'h1000 + 16'(k);
      tick();  // first ACCESS cycle
      check($sformatf("rr%0d_a_out", k), bus_if.a_out, (k % 2 == 0) ? 16'h0100 : 16'h0200);
      tick();
      check($sformatf("rr%0d_no_rdy", k),
            16'({bus_if.cpu_rdy_out, bus_if.dma_rdy_out}), 16'h0000);
      tick();  // DONE
      check($sformatf("rr%0d_cpu_rdy", k), 16'(bus_if.cpu_rdy_out), (k % 2 == 0) ? 16'h0001 : 16'h0000);
      check($sformatf("rr%0d_dma_rdy", k), 16'(bus_if.dma_rdy_out), (k % 2 == 0) ? 16'h0000 : 16'h0001);
      check($sformatf("rr%0d_rdata", k),
            (k % 2 == 0) ? bus_if.cpu_d_out : bus_if.dma_d_out, 16'h1000 + 16'(k));
      if (k == 3) begin
        bus_if.cpu_req_in = 0;
        bus_if.dma_req_in = 0;
      end
      tick();  // IDLE
      check($sformatf("rr%0d_idle_rdy", k),
            16'({bus_if.cpu_rdy_out, bus_if.dma_rdy_out}), 16'h0000);
    end

    // ---- Request latched: address change during ACCESS is ignored ----
    bus_if.cpu_req_in = 1; bus_if.cpu_a_in = 16'h0010;
    tick();
    check("lat_c1_a_out", bus_if.a_out, 16'h0010);
    bus_if.cpu_a_in = 16'h0020;
    tick();
    check("lat_c2_a_out", bus_if.a_out, 16'h0010);
    tick();
    check("lat_c3_cpu_rdy", 16'(bus_if.cpu_rdy_out), 16'h0001);
    check("lat_c3_a_out",   bus_if.a_out,            16'h0000);
    bus_if.cpu_req_in = 0;
    tick();

    // ---- Reset in the second ACCESS cycle of a CPU memory write ----
    bus_if.cpu_req_in = 1; bus_if.cpu_a_in = 16'h0055; bus_if.cpu_d_in = 16'hAAAA;
    bus_if.cpu_wen_in = 1;
    tick();  // cycle 1
    check("rm_c1_a_out", bus_if.a_out,        16'h0055);
    check("rm_c1_wen",   16'(bus_if.wen_out), 16'h0000);
    @(posedge clk);
    rst = 1'b1;
    #1;
    check("rm_wen",     16'(bus_if.wen_out),     16'h0000);
    check("rm_a_out",   bus_if.a_out,            16'h0000);
    check("rm_d_out",   bus_if.d_out,            16'h0000);
    check("rm_cpu_rdy", 16'(bus_if.cpu_rdy_out), 16'h0000);
    bus_if.cpu_req_in = 0; bus_if.cpu_wen_in = 0;
    bus_if.dma_req_in = 1; bus_if.dma_a_in = 16'h0077; bus_if.d_in = 16'h3C3C;
    tick();
    rst = 1'b0;
    tick();
    check("rm_dma_a_out",   bus_if.a_out,            16'h0077);
    check("rm_cpu_rdy2",    16'(bus_if.cpu_rdy_out), 16'h0000);
    tick();
    tick();
    check("rm_dma_rdy",     16'(bus_if.dma_rdy_out), 16'h0001);
    check("rm_dma_d",       bus_if.dma_d_out,        16'h3C3C);
    check("rm_cpu_rdy3",    16'(bus_if.cpu_rdy_out), 16'h0000);
    bus_if.dma_req_in = 0;
    tick();

    // ---- Zero wait cycles: one ACCESS cycle carrying the write strobe ----
    bus0_if.cpu_req_in = 1; bus0_if.cpu_a_in = 16'h0009; bus0_if.cpu_d_in = 16'h9999;
    bus0_if.cpu_wen_in = 1;
    tick();
    check("w0_a_out", bus0_if.a_out,        16'h0009);
    check("w0_wen",   16'(bus0_if.wen_out), 16'h0001);
    check("w0_d_out", bus0_if.d_out,        16'h9999);
    tick();
    check("w0_cpu_rdy", 16'(bus0_if.cpu_rdy_out), 16'h0001);
    check("w0_wen2",    16'(bus0_if.wen_out),     16'h0000);
    bus0_if.cpu_req_in = 0; bus0_if.cpu_wen_in = 0;
    tick();

`ifdef BUS_ARB_PERF_EN
    // ---- Grant counters: alternating CPU,DMA,CPU,DMA,CPU after reset ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("perf_rst_cpu", bus_if.cpu_grants_out, 16'h0000);
    bus_if.cpu_req_in = 1; bus_if.dma_req_in = 1;
    bus_if.cpu_a_in = 16'h0001; bus_if.dma_a_in = 16'h0002;
    for (int k = 0; k < 19; k++) tick();
    bus_if.cpu_req_in = 0; bus_if.dma_req_in = 0;
    tick();
    check("perf_cpu", bus_if.cpu_grants_out, 16'd3);
    check("perf_dma", bus_if.dma_grants_out, 16'd2);
    dut.cpu_grants_q = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      bus_if.cpu_req_in = 1;
      tick(); tick(); tick();
      bus_if.cpu_req_in = 0;
      tick();
    end
    check("perf_sat", bus_if.cpu_grants_out, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shares the CPU's external memory/IO bus between the CPU core and a DMA engine. The arbiter sits between the requesters and the pins that drive memory and IO: a_out, d_out, wen_out, iom_out, d_in, io_in. It grants one requester at a time using round-robin arbitration and inserts a parameterised number of wait cycles per access. It returns read data and a one-cycle ready pulse to the granted requester.

## Interface
Parameters:
- WAIT_MEM, default 1: extra wait cycles for a memory access (iom=0).
- WAIT_IO, default 2: extra wait cycles for an IO access (iom=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req_in  in  1  CPU bus request.
- cpu_a_in  in  16  CPU address.
- cpu_d_in  in  16  CPU write data.
- cpu_wen_in  in  1  CPU write enable; 1 = write.
- cpu_iom_in  in  1  CPU space select; 1 = IO, 0 = memory.
- cpu_rdy_out  out  1  CPU access complete; one-cycle pulse.
- cpu_d_out  out  16  CPU read data; valid when cpu_rdy_out is high.
- dma_req_in, dma_a_in, dma_d_in, dma_wen_in, dma_iom_in, dma_rdy_out, dma_d_out: same as the cpu_* ports, for the DMA requester.
- a_out  out  16  bus address.
- d_out  out  16  bus write data.
- wen_out  out  1  bus write strobe.
- iom_out  out  1  bus space select.
- d_in  in  16  memory read data.
- io_in  in  16  IO read data.
- Ports present only with BUS_ARB_PERF_EN: cpu_grants_out out 16, dma_grants_out out 16.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Sample both req lines.
  - If neither is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the requester not granted last (last_grant register).
  - On a grant: latch that requester's a/d/wen/iom, set last_grant, load wait counter with WAIT_IO if iom=1 else WAIT_MEM, go to ACCESS.
- ACCESS:
  - a_out, d_out and iom_out are driven from the latched request.
  - Counter decrements each cycle.
  - When counter==0: wen_out = latched wen for that single cycle only.
  - When counter==0: capture read data (io_in if iom=1, else d_in) into the grantee's d_out register, then go to DONE.
- DONE:
  - The grantee's rdy_out is high for exactly this cycle; then go to IDLE.
  - The non-granted rdy_out stays 0.
- Requester rules:
  - Hold req and a/d/wen/iom stable from assertion until rdy.
  - Drop req or present a new request at the edge ending DONE.
  - A req still high in the IDLE after DONE is a new access.
- Write data is not returned: the grantee's d_out register is still loaded from the bus on writes and has no defined meaning.
- Fairness: with both requesting continuously, grants strictly alternate.
- Latched address/data are held internally; input changes during ACCESS are ignored.

## Timing
- Reset values:
  - state=IDLE, last_grant=DMA (so the CPU wins the first tie).
  - Counter 0; all bus outputs 0; both rdy_out 0; both d_out 0; perf counters 0.
- Outside ACCESS: a_out, d_out, wen_out, iom_out are 0.
- Latency from req sampled in IDLE (cycle N):
  - ACCESS spans N+1 .. N+1+W, where W = WAIT_MEM or WAIT_IO.
  - rdy is high at cycle N+2+W.
  - Next grant is possible at N+3+W.
- W=0 is legal: ACCESS lasts one cycle and wen_out pulses in it.
- All outputs are registered; no combinational path from inputs to outputs.
- rst asserted mid-access: immediate return to reset values. The write strobe is aborted and the requester gets no rdy.

## Configuration
- BUS_ARB_PERF_EN defined: adds ports cpu_grants_out and dma_grants_out.
  - Each is a 16-bit counter that increments on every grant to that requester.
  - Counters saturate at 0xFFFF and clear only on rst.
- BUS_ARB_PERF_EN undefined: the ports and counters do not exist; arbitration behaviour is identical.

## Structure
- mycpu_pkg gains:
  - arb_state_t enum {IDLE, ACCESS, DONE}.
  - arb_id_t enum {ARB_CPU, ARB_DMA}.
  - Constant ARB_CNT_W = 4; WAIT_MEM and WAIT_IO must be at most 15.
- Sub-module arb_wait_cnt holds the loadable down-counter.
  - Inputs: load, load value, enable.
  - Output: zero flag.
- FSM, grant logic and bus latches live in bus_arbiter.

## Test plan
- CPU memory read, defaults: a=0x0040, d_in=0xBEEF, req in IDLE at cycle 0 -> a_out=0x0040 in cycles 1–2; cpu_rdy_out=1 at cycle 3 with cpu_d_out=0xBEEF; dma_rdy_out stays 0.
- DMA IO write: a=0x0003, d=0x1234, iom=1 -> ACCESS cycles 1–3; wen_out=1 only in cycle 3; d_out=0x1234; iom_out=1; dma_rdy_out at cycle 4.
- Both requesting continuously after reset -> grant order CPU, DMA, CPU, DMA; each rdy pulse is one cycle; no overlap.
- CPU changes cpu_a_in from 0x0010 to 0x0020 during its ACCESS -> a_out stays 0x0010 until the access ends.
- rst asserted in the second ACCESS cycle of a memory write -> wen_out never pulses; outputs are 0 immediately; after release, a pending DMA request is granted first only if the CPU is not requesting.
- With BUS_ARB_PERF_EN: 3 CPU and 2 DMA accesses -> cpu_grants_out=3, dma_grants_out=2; a counter preset near saturation holds at 0xFFFF.
